// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: CPU request/response, cam lookup/write and memory burst
// signals of the blocking write-back cache controller.
//   master : the controller view (drives req_ready, resp_*, cam_*_req/index/
//            tag/data/mask/flags, mem_req_*, mem_w*)
//   slave  : the environment view (CPU, cam array and memory bus)
interface dcache_ctrl_if;
  // CPU side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [26:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  // cam lookup
  logic        cam_read_req;
  logic [9:0]  cam_read_index;
  logic [16:0] cam_read_tag_in;
  logic        cam_read_hit;
  logic [16:0] cam_read_tag_out;
  logic [31:0] cam_read_data;
  logic [1:0]  cam_read_flags;
  // cam writes
  logic [9:0]  cam_write_index;
  logic        cam_write_req_data;
  logic [31:0] cam_write_data;
  logic [3:0]  cam_write_mask;
  logic        cam_write_req_tag_flags;
  logic [16:0] cam_write_tag;
  logic [1:0]  cam_write_flags;
  // memory bus
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [24:0] mem_req_addr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_mask,
    output req_ready, resp_valid, resp_rdata,
    output cam_read_req, cam_read_index, cam_read_tag_in,
    input  cam_read_hit, cam_read_tag_out, cam_read_data, cam_read_flags,
    output cam_write_index, cam_write_req_data, cam_write_data, cam_write_mask,
    output cam_write_req_tag_flags, cam_write_tag, cam_write_flags,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata,
    input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_mask,
    input  req_ready, resp_valid, resp_rdata,
    input  cam_read_req, cam_read_index, cam_read_tag_in,
    output cam_read_hit, cam_read_tag_out, cam_read_data, cam_read_flags,
    input  cam_write_index, cam_write_req_data, cam_write_data, cam_write_mask,
    input  cam_write_req_tag_flags, cam_write_tag, cam_write_flags,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_wvalid, mem_wdata,
    output mem_req_ready, mem_wready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking write-back controller in front of a 2-way cam array.
// 16 B lines; word address bits: [26:10] tag, [9:2] set, [1:0] word.
// One CPU access at a time: lookup, hit load/store, or on a miss write back a
// dirty LRU victim, refill the line and replay the access.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : dcache_ctrl_if.master (CPU request/response, cam, memory bus)
module dcache_ctrl #(
  parameter int unsigned BEATS = 4
) (
  input  logic          clk,
  input  logic          reset,
  dcache_ctrl_if.master bus
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_RD, WB_BEAT, FILL_REQ, FILL, TAG_WR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [26:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic [16:0] vtag_q, vtag_d;
  logic [31:0] wb_q;
  logic        wb_have_q;

  logic [7:0]  set_w;
  assign set_w = addr_q[9:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      vtag_q    <= '0;
      wb_q      <= '0;
      wb_have_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vtag_q  <= vtag_d;
      if (state_q == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mask_q  <= bus.req_mask;
      end
      // The victim word arrives the cycle after WB_RD; capture it on the first
      // WB_BEAT cycle so the beat stays stable however long wready is held off.
      if (state_q == WB_BEAT) begin
        if (!wb_have_q) wb_q <= bus.cam_read_data;
        wb_have_q <= !bus.mem_wready;
      end else begin
        wb_have_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vtag_d  = vtag_q;

    bus.req_ready               = 1'b0;
    bus.resp_valid              = 1'b0;
    bus.resp_rdata              = '0;
    bus.cam_read_req            = 1'b0;
    bus.cam_read_index          = '0;
    bus.cam_read_tag_in         = addr_q[26:10];
    bus.cam_write_index         = '0;
    bus.cam_write_req_data      = 1'b0;
    bus.cam_write_data          = '0;
    bus.cam_write_mask          = '0;
    bus.cam_write_req_tag_flags = 1'b0;
    bus.cam_write_tag           = '0;
    bus.cam_write_flags         = '0;
    bus.mem_req_valid           = 1'b0;
    bus.mem_req_write           = 1'b0;
    bus.mem_req_addr            = '0;
    bus.mem_wvalid              = 1'b0;
    bus.mem_wdata               = '0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          bus.cam_read_req   = 1'b1;
          bus.cam_read_index = bus.req_addr[9:0];
          state_d            = LOOKUP;
        end
      end

      LOOKUP: begin
        bus.cam_write_index = addr_q[9:0];
        if (bus.cam_read_hit) begin
          bus.resp_valid = 1'b1;
          if (write_q) begin
            bus.cam_write_req_data      = 1'b1;
            bus.cam_write_data          = wdata_q;
            bus.cam_write_mask          = mask_q;
            bus.cam_write_req_tag_flags = 1'b1;
            bus.cam_write_tag           = bus.cam_read_tag_out;
            bus.cam_write_flags         = 2'b11;
          end else begin
            bus.resp_rdata = bus.cam_read_data;
          end
          state_d = IDLE;
        end else begin
          vtag_d  = bus.cam_read_tag_out;
          state_d = (bus.cam_read_flags == 2'b11) ? WB_REQ : FILL_REQ;
        end
      end

      WB_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = {vtag_q, set_w};
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = WB_RD;
        end
      end

      WB_RD: begin
        bus.cam_read_req   = 1'b1;
        bus.cam_read_index = {set_w, cnt_q};
        state_d            = WB_BEAT;
      end

      WB_BEAT: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = wb_have_q ? wb_q : bus.cam_read_data;
        if (bus.mem_wready) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == LAST_BEAT) ? FILL_REQ : WB_RD;
        end
      end

      FILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = addr_q[26:2];
        cnt_d             = '0;
        if (bus.mem_req_ready) state_d = FILL;
      end

      FILL: begin
        if (bus.mem_rvalid) begin
          bus.cam_write_req_data = 1'b1;
          bus.cam_write_index    = {set_w, cnt_q};
          bus.cam_write_data     = bus.mem_rdata;
          bus.cam_write_mask     = 4'hF;
          cnt_d                  = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) state_d = TAG_WR;
        end
      end

      TAG_WR: begin
        // Tag write commits on this edge, so the replay lookup issued alongside
        // it sees the new line on the following LOOKUP cycle.
        bus.cam_write_req_tag_flags = 1'b1;
        bus.cam_write_index         = addr_q[9:0];
        bus.cam_write_tag           = addr_q[26:10];
        bus.cam_write_flags         = 2'b01;
        bus.cam_read_req            = 1'b1;
        bus.cam_read_index          = addr_q[9:0];
        state_d                     = LOOKUP;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a behavioural 2-way cam
// (LRU, valid/dirty flags) and a memory responder that logs burst requests and
// writeback beats. Refill beat k of line L carries 0xF0000000 | L<<8 | (k+1).
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic cam_clr;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl #(.BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fdata(input logic [24:0] line, input int unsigned k);
    return 32'hF000_0000 | ({7'd0, line} << 8) | 32'(k + 1);
  endfunction

  // ---------------- cam model ----------------
  logic [16:0] ctag [2][256];
  logic [1:0]  cflg [2][256];
  logic [31:0] cdat [2][1024];
  logic        clru [256];
  logic [9:0]  ridx_q;
  logic        pend_q;
  logic [7:0]  rset;
  logic        h0, h1, chit, hway, sway, wway;

  always_comb begin
    rset = ridx_q[9:2];
    h0   = cflg[0][rset][0] && (ctag[0][rset] == bus.cam_read_tag_in);
    h1   = cflg[1][rset][0] && (ctag[1][rset] == bus.cam_read_tag_in);
    chit = h0 | h1;
    hway = !h0;
    sway = chit ? hway : clru[rset];
    wway = (pend_q && chit) ? hway : clru[bus.cam_write_index[9:2]];
    bus.cam_read_hit     = chit;
    bus.cam_read_tag_out = ctag[sway][rset];
    bus.cam_read_flags   = cflg[sway][rset];
    bus.cam_read_data    = cdat[sway][ridx_q];
  end

  always @(posedge clk) begin
    if (cam_clr) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < 256; s++) begin
          ctag[w][s] <= '0;
          cflg[w][s] <= '0;
        end
        for (int i = 0; i < 1024; i++) cdat[w][i] <= '0;
      end
      for (int s = 0; s < 256; s++) clru[s] <= 1'b0;
      ridx_q <= '0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= bus.cam_read_req;
      if (bus.cam_read_req) ridx_q <= bus.cam_read_index;
      if (pend_q && chit) clru[rset] <= ~hway;
      if (bus.cam_write_req_data)
        for (int b = 0; b < 4; b++)
          if (bus.cam_write_mask[b])
            cdat[wway][bus.cam_write_index][8*b +: 8] <= bus.cam_write_data[8*b +: 8];
      if (bus.cam_write_req_tag_flags) begin
        ctag[wway][bus.cam_write_index[9:2]] <= bus.cam_write_tag;
        cflg[wway][bus.cam_write_index[9:2]] <= bus.cam_write_flags;
      end
    end
  end

  // ---------------- memory responder / monitor ----------------
  logic [25:0] req_log [$];
  logic [31:0] wb_log  [$];
  int          fill_left   = 0;
  logic [24:0] fill_line   = '0;
  int          req_wait    = 0;
  int          stall_left  = 0;
  int          stall_seen  = 0;
  int          wdata_moved = 0;
  int          overlap     = 0;
  bit          have_stall  = 1'b0;
  logic [31:0] stall_data  = '0;

  initial begin : env
    bus.mem_req_ready = 1'b1;
    bus.mem_wready    = 1'b1;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          req_log.push_back({bus.mem_req_write, bus.mem_req_addr});
          if (!bus.mem_req_write) begin
            fill_left = 4;
            fill_line = bus.mem_req_addr;
          end
        end
        if (bus.mem_wvalid) begin
          if (have_stall && bus.mem_wdata != stall_data) wdata_moved++;
          if (bus.mem_wready) begin
            wb_log.push_back(bus.mem_wdata);
            have_stall = 1'b0;
          end else begin
            stall_seen++;
            stall_data = bus.mem_wdata;
            have_stall = 1'b1;
          end
        end
        if (bus.cam_read_req && bus.cam_write_req_data &&
            bus.cam_read_index == bus.cam_write_index) overlap++;
      end
      @(posedge clk);
      #1;
      bus.mem_req_ready = 1'b1;
      bus.mem_wready    = 1'b1;
      bus.mem_rvalid    = 1'b0;
      bus.mem_rdata     = '0;
      if (reset) begin
        fill_left  = 0;
        have_stall = 1'b0;
      end else begin
        if (fill_left > 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = fdata(fill_line, 32'(4 - fill_left));
          fill_left--;
        end
        if (bus.mem_req_valid && req_wait > 0) begin
          bus.mem_req_ready = 1'b0;
          req_wait--;
          if (!bus.mem_rvalid) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hDEAD_BEEF;
          end
        end
        if (bus.mem_wvalid && wb_log.size() == 2 && stall_left > 0) begin
          bus.mem_wready = 1'b0;
          stall_left--;
        end
      end
    end
  end

  function automatic logic [25:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : '1;
  endfunction

  function automatic logic [31:0] wb_at(input int i);
    return (i < wb_log.size()) ? wb_log[i] : 32'hFFFF_FFFF;
  endfunction

  // ---------------- CPU driver ----------------
  task automatic start_req(input logic wr, input logic [31:0] baddr,
                           input logic [31:0] wd, input logic [3:0] m);
    int n;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = baddr[28:2];
    bus.req_wdata = wd;
    bus.req_mask  = m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 50);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic cpu_op(input string tag, input logic wr, input logic [31:0] baddr,
                        input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] rd, output int lat);
    bit ok;
    ok  = 1'b0;
    rd  = '0;
    lat = 0;
    start_req(wr, baddr, wd, m);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        rd  = bus.resp_rdata;
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    check_eq({tag, "_resp"}, 64'(ok), 64'd1);
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {bus.req_ready, bus.resp_valid, bus.mem_req_valid, bus.mem_wvalid,
            bus.cam_read_req, bus.cam_write_req_data, bus.cam_write_req_tag_flags};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int          lat;
    int          n;

    reset         = 1'b1;
    cam_clr       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctrl", 64'(ctrl_vec()), 64'b1000000);
    reset   = 1'b0;
    cam_clr = 1'b0;

    // Cold load: one refill, no writeback
    req_log.delete(); wb_log.delete();
    cpu_op("cold", 1'b0, 32'h1000, '0, '0, rd, lat);
    check_eq("cold_rdata", 64'(rd), 64'hF001_0001);
    check_eq("cold_lat", 64'(lat), 64'd8);
    check_eq("cold_nreq", 64'(req_log.size()), 64'd1);
    check_eq("cold_req0", 64'(req_at(0)), {38'd0, 1'b0, 25'h100});
    check_eq("cold_nwb", 64'(wb_log.size()), 64'd0);

    // Repeat load: hit in one cycle
    req_log.delete();
    cpu_op("hit", 1'b0, 32'h1000, '0, '0, rd, lat);
    check_eq("hit_lat", 64'(lat), 64'd1);
    check_eq("hit_rdata", 64'(rd), 64'hF001_0001);
    check_eq("hit_nreq", 64'(req_log.size()), 64'd0);

    // Partial store then reload
    cpu_op("st", 1'b1, 32'h1004, 32'hAABB_CCDD, 4'b0011, rd, lat);
    check_eq("st_lat", 64'(lat), 64'd1);
    check_eq("st_rdata", 64'(rd), 64'd0);
    cpu_op("ld", 1'b0, 32'h1004, '0, '0, rd, lat);
    check_eq("ld_merge", 64'(rd), 64'hF001_CCDD);
    check_eq("st_flags", 64'(cflg[0][0]), 64'd3);

    // Same-set load into the clean way; request held off with early rvalids
    req_log.delete(); wb_log.delete();
    req_wait = 2;
    cpu_op("l2", 1'b0, 32'h2000, '0, '0, rd, lat);
    check_eq("l2_rdata", 64'(rd), 64'hF002_0001);
    check_eq("l2_nreq", 64'(req_log.size()), 64'd1);
    check_eq("l2_req0", 64'(req_at(0)), {38'd0, 1'b0, 25'h200});

    // Evict the dirty line with a 5-cycle wready stall on beat 2
    req_log.delete(); wb_log.delete();
    stall_seen = 0; wdata_moved = 0; stall_left = 5;
    cpu_op("l3", 1'b0, 32'h3000, '0, '0, rd, lat);
    check_eq("l3_rdata", 64'(rd), 64'hF003_0001);
    check_eq("l3_nreq", 64'(req_log.size()), 64'd2);
    check_eq("l3_req0", 64'(req_at(0)), {38'd0, 1'b1, 25'h100});
    check_eq("l3_req1", 64'(req_at(1)), {38'd0, 1'b0, 25'h300});
    check_eq("l3_nwb", 64'(wb_log.size()), 64'd4);
    check_eq("wb_beat0", 64'(wb_at(0)), 64'hF001_0001);
    check_eq("wb_beat1", 64'(wb_at(1)), 64'hF001_CCDD);
    check_eq("wb_beat2", 64'(wb_at(2)), 64'hF001_0003);
    check_eq("wb_beat3", 64'(wb_at(3)), 64'hF001_0004);
    check_eq("wb_stall", 64'(stall_seen), 64'd5);
    check_eq("wb_stable", 64'(wdata_moved), 64'd0);

    // Reset while refill beat 2 is on the bus
    req_log.delete();
    start_req(1'b0, 32'h4000, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fill_left != 1 && n < 100);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_ctrl", 64'(ctrl_vec()), 64'b1000000);
    check_eq("rst_mid_addr", {12'd0, bus.mem_req_addr, bus.cam_read_tag_in, bus.cam_write_index}, 64'd0);
    check_eq("rst_mid_data", {bus.mem_wdata, bus.resp_rdata}, 64'd0);
    check_eq("rst_mid_nreq", 64'(req_log.size()), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    req_log.delete();
    cpu_op("rst_re", 1'b0, 32'h4000, '0, '0, rd, lat);
    check_eq("rst_re_rdata", 64'(rd), 64'hF004_0001);
    check_eq("rst_re_lat", 64'(lat), 64'd8);
    check_eq("rst_re_nreq", 64'(req_log.size()), 64'd1);
    check_eq("rst_re_req0", 64'(req_at(0)), {38'd0, 1'b0, 25'h400});

    check_eq("rd_wr_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
